// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of a byte-addressed data memory.
// Supports bounded ownership locks, rejects illegal accesses, returns registered responses.
module dmem_arbiter #(
    parameter int DEPTH    = 1024,
    parameter int MAX_LOCK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_wa,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_lock,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_wa,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [1:0]  mem_wa,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

    owner_e      owner_q, owner_d;
    logic        last_m1_q, last_m1_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic        m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
    logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic        gnt0, gnt1, granted;
    logic        win_we, win_lock, illegal;
    logic [1:0]  win_wa;
    logic [31:0] win_addr, win_wdata, masked, resp_data;
    logic [32:0] last_byte, nbytes;
    logic [CW:0] cnt_inc;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (owner_q)
                OWN_M0:  gnt0 = m0_req;
                OWN_M1:  gnt1 = m1_req;
                default: begin
                    // On a tie the master that did not win last time goes first.
                    if (m0_req && m1_req) begin
                        gnt0 = last_m1_q;
                        gnt1 = !last_m1_q;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                end
            endcase
        end
        granted = gnt0 | gnt1;

        win_we    = gnt1 ? m1_we    : m0_we;
        win_wa    = gnt1 ? m1_wa    : m0_wa;
        win_addr  = gnt1 ? m1_addr  : m0_addr;
        win_wdata = gnt1 ? m1_wdata : m0_wdata;
        win_lock  = gnt1 ? m1_lock  : m0_lock;

        case (win_wa)
            2'd0:    nbytes = 33'd1;
            2'd1:    nbytes = 33'd2;
            default: nbytes = 33'd4;
        endcase
        last_byte = {1'b0, win_addr} + nbytes - 33'd1;
        illegal = (win_wa == 2'd3)
               || (win_wa == 2'd1 && win_addr[0])
               || (win_wa == 2'd2 && win_addr[1:0] != 2'd0)
               || (last_byte >= 33'(DEPTH));

        case (win_wa)
            2'd0:    masked = {24'd0, mem_rdata[7:0]};
            2'd1:    masked = {16'd0, mem_rdata[15:0]};
            default: masked = mem_rdata;
        endcase
        resp_data = (!illegal && !win_we) ? masked : 32'd0;
    end

    always_comb begin
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        last_m1_d  = last_m1_q;
        cnt_inc    = {1'b0, lock_cnt_q} + {{CW{1'b0}}, 1'b1};
        if (granted) begin
            last_m1_d = gnt1;
            if (win_lock && cnt_inc < (CW+1)'(MAX_LOCK)) begin
                owner_d    = gnt1 ? OWN_M1 : OWN_M0;
                lock_cnt_d = cnt_inc[CW-1:0];
            end else begin
                owner_d    = OWN_NONE;
                lock_cnt_d = '0;
            end
        end else if (owner_q != OWN_NONE) begin
            // Locked owner stopped requesting: ownership lapses.
            owner_d    = OWN_NONE;
            lock_cnt_d = '0;
        end

        m0_rvalid_d = gnt0;
        m0_err_d    = gnt0 & illegal;
        m0_rdata_d  = gnt0 ? resp_data : 32'd0;
        m1_rvalid_d = gnt1;
        m1_err_d    = gnt1 & illegal;
        m1_rdata_d  = gnt1 ? resp_data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            last_m1_q   <= 1'b1;
            lock_cnt_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m0_err_q    <= 1'b0;
            m0_rdata_q  <= 32'd0;
            m1_rvalid_q <= 1'b0;
            m1_err_q    <= 1'b0;
            m1_rdata_q  <= 32'd0;
        end else begin
            owner_q     <= owner_d;
            last_m1_q   <= last_m1_d;
            lock_cnt_q  <= lock_cnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m0_err_q    <= m0_err_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rvalid_q <= m1_rvalid_d;
            m1_err_q    <= m1_err_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign mem_addr  = win_addr;
    assign mem_wdata = win_wdata;
    assign mem_wa    = win_wa;
    assign mem_we    = granted & win_we & ~illegal;
    assign m0_rvalid = m0_rvalid_q;
    assign m0_err    = m0_err_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m1_err    = m1_err_q;
    assign m1_rdata  = m1_rdata_q;

endmodule
